pcie_os_tx: RTL and testbench

- Ordered-set transmitter for the Gen1/Gen2 (8b/10b) LTSSM path. It takes ordered-set requests from LTSSM control logic, including the repeat count and TS field values.
- It emits the symbol stream to the PHY as an AXIS master, 4 symbols per beat, with per-symbol K-character flags in tuser.
- It also inserts SKP ordered sets on a programmable interval, only at ordered-set boundaries.
- It is the transmit counterpart to the LTSSM's AXIS receive path from the PHY.

---
 rtl/pcie_os_tx.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pcie_os_tx.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_os_tx.sv
// pcie_os_tx: ordered-set transmitter for the 8b/10b (Gen1/Gen2) LTSSM path.
// Accepts TS1/TS2/EIOS/EIEOS requests and streams them to the PHY as an AXIS master,
// 4 symbols per beat (symbol n in byte n), with per-byte K flags in tuser. SKP ordered
// sets are inserted on a programmable beat interval, only between ordered sets.
// Ports:
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   req_*                           request handshake and latched TS field values
//   skp_en_i                        enables periodic SKP insertion
//   m_axis_*                        AXIS master symbol stream to the PHY
//   os_sent_o, done_o, busy_o       per-ordered-set / per-request status
module pcie_os_tx #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = KEEP_WIDTH,
  parameter int unsigned SKP_INTERVAL = 354,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_type_i,
  input  logic [CNT_WIDTH-1:0]  req_count_i,
  input  logic [7:0]            req_link_i,
  input  logic                  req_link_pad_i,
  input  logic [4:0]            req_lane_i,
  input  logic                  req_lane_pad_i,
  input  logic [7:0]            req_nfts_i,
  input  logic [7:0]            req_rate_i,
  input  logic [7:0]            req_ctrl_i,
  input  logic                  skp_en_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
  output logic                  m_axis_tvalid_o,
  output logic                  m_axis_tlast_o,
  output logic [USER_WIDTH-1:0] m_axis_tuser_o,
  input  logic                  m_axis_tready_i,
  output logic                  os_sent_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int unsigned TMR_W = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_EIE = 8'hFC;
  localparam logic [7:0] ID_TS1  = 8'h4A;
  localparam logic [7:0] ID_TS2  = 8'h45;

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("pcie_os_tx: only DATA_WIDTH=32 is supported");
  end
  if (SKP_INTERVAL < 8) begin : g_bad_skp_interval
    $error("pcie_os_tx: SKP_INTERVAL must be >= 8");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_SKP} state_e;
  typedef enum logic [1:0] {OS_TS1, OS_TS2, OS_EIOS, OS_EIEOS} os_e;

  state_e                state_q, state_d;
  os_e                   type_q, type_d;
  logic [1:0]            beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic [7:0]            link_q, link_d;
  logic                  link_pad_q, link_pad_d;
  logic [4:0]            lane_q, lane_d;
  logic                  lane_pad_q, lane_pad_d;
  logic [7:0]            nfts_q, nfts_d;
  logic [7:0]            rate_q, rate_d;
  logic [7:0]            ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  skp_pend_q, skp_pend_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;
  logic                  tlast_q, tlast_d;
  logic                  tvalid_q, tvalid_d;

  logic       hs_c;
  logic       skp_go_c;
  logic       os_end_c;
  logic [1:0] last_idx_c;
  logic [7:0] id_c;
  logic [7:0] link_sym_c;
  logic [7:0] lane_sym_c;

  assign hs_c       = tvalid_q & m_axis_tready_i;
  assign skp_go_c   = skp_pend_q & skp_en_i;
  assign last_idx_c = (type_q == OS_EIOS) ? 2'd0 : 2'd3;
  assign os_end_c   = (state_q == ST_SEND) & hs_c & (beat_q == last_idx_c);

  // Status pulses coincide with the tlast handshake itself
  assign os_sent_o   = os_end_c;
  assign done_o      = os_end_c & (remaining_q == CNT_WIDTH'(1));
  assign busy_o      = busy_q;
  assign req_ready_o = (state_q == ST_IDLE) & ~skp_go_c;

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tuser_o  = tuser_q;
  assign m_axis_tlast_o  = tlast_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign m_axis_tkeep_o  = '1;

  // Next-state, SKP timer and next output beat
  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    beat_d      = beat_q;
    remaining_d = remaining_q;
    link_d      = link_q;
    link_pad_d  = link_pad_q;
    lane_d      = lane_q;
    lane_pad_d  = lane_pad_q;
    nfts_d      = nfts_q;
    rate_d      = rate_q;
    ctrl_d      = ctrl_q;
    busy_d      = busy_q;
    skp_pend_d  = skp_pend_q;
    tmr_d       = tmr_q;
    tdata_d     = '0;
    tuser_d     = '0;
    tlast_d     = 1'b0;
    tvalid_d    = 1'b0;
    id_c        = ID_TS1;
    link_sym_c  = 8'h00;
    lane_sym_c  = 8'h00;

    // Free-running SKP timer; pending is sticky and cleared by the SKP handshake
    if (!skp_en_i) begin
      tmr_d      = '0;
      skp_pend_d = 1'b0;
    end else begin
      if (tmr_q == TMR_W'(SKP_INTERVAL - 1)) begin
        tmr_d      = '0;
        skp_pend_d = 1'b1;
      end else begin
        tmr_d = tmr_q + TMR_W'(1);
      end
      if ((state_q == ST_SKP) && hs_c) begin
        skp_pend_d = 1'b0;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (skp_go_c) begin
          state_d = ST_SKP;
        end else if (req_valid_i) begin
          unique case (req_type_i)
            3'd1:    type_d = OS_TS2;
            3'd2:    type_d = OS_EIOS;
            3'd3:    type_d = OS_EIEOS;
            default: type_d = OS_TS1;
          endcase
          link_d      = req_link_i;
          link_pad_d  = req_link_pad_i;
          lane_d      = req_lane_i;
          lane_pad_d  = req_lane_pad_i;
          nfts_d      = req_nfts_i;
          rate_d      = req_rate_i;
          ctrl_d      = req_ctrl_i;
          remaining_d = (req_count_i == '0) ? CNT_WIDTH'(1) : req_count_i;
          beat_d      = 2'd0;
          busy_d      = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs_c) begin
          if (beat_q == last_idx_c) begin
            remaining_d = remaining_q - CNT_WIDTH'(1);
            beat_d      = 2'd0;
            if (remaining_q == CNT_WIDTH'(1)) begin
              busy_d  = 1'b0;
              state_d = skp_go_c ? ST_SKP : ST_IDLE;
            end else if (skp_go_c) begin
              state_d = ST_SKP;
            end
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end
      end
      ST_SKP: begin
        if (hs_c) begin
          beat_d  = 2'd0;
          state_d = (remaining_q != '0) ? ST_SEND : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output beat is a function of the next state so it is held while stalled
    id_c       = (type_d == OS_TS2) ? ID_TS2 : ID_TS1;
    link_sym_c = link_pad_d ? SYM_PAD : link_d;
    lane_sym_c = lane_pad_d ? SYM_PAD : {3'b000, lane_d};
    unique case (state_d)
      ST_SKP: begin
        tvalid_d = 1'b1;
        tlast_d  = 1'b1;
        tdata_d  = {SYM_SKP, SYM_SKP, SYM_SKP, SYM_COM};
        tuser_d  = 4'hF;
      end
      ST_SEND: begin
        tvalid_d = 1'b1;
        unique case (type_d)
          OS_EIOS: begin
            tlast_d = 1'b1;
            tdata_d = {SYM_IDL, SYM_IDL, SYM_IDL, SYM_COM};
            tuser_d = 4'hF;
          end
          OS_EIEOS: begin
            tlast_d = (beat_d == 2'd3);
            unique case (beat_d)
              2'd0: begin
                tdata_d = {SYM_EIE, SYM_EIE, SYM_EIE, SYM_COM};
                tuser_d = 4'hF;
              end
              2'd3: begin
                tdata_d = {ID_TS1, SYM_EIE, SYM_EIE, SYM_EIE};
                tuser_d = 4'b0111;
              end
              default: begin
                tdata_d = {SYM_EIE, SYM_EIE, SYM_EIE, SYM_EIE};
                tuser_d = 4'hF;
              end
            endcase
          end
          default: begin
            tlast_d = (beat_d == 2'd3);
            unique case (beat_d)
              2'd0: begin
                tdata_d = {nfts_d, lane_sym_c, link_sym_c, SYM_COM};
                tuser_d = {1'b0, lane_pad_d, link_pad_d, 1'b1};
              end
              2'd1: tdata_d = {id_c, id_c, ctrl_d, rate_d};
              default: tdata_d = {id_c, id_c, id_c, id_c};
            endcase
          end
        endcase
      end
      default: ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      type_q      <= OS_TS1;
      beat_q      <= 2'd0;
      remaining_q <= '0;
      link_q      <= 8'h00;
      link_pad_q  <= 1'b0;
      lane_q      <= 5'd0;
      lane_pad_q  <= 1'b0;
      nfts_q      <= 8'h00;
      rate_q      <= 8'h00;
      ctrl_q      <= 8'h00;
      busy_q      <= 1'b0;
      skp_pend_q  <= 1'b0;
      tmr_q       <= '0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      beat_q      <= beat_d;
      remaining_q <= remaining_d;
      link_q      <= link_d;
      link_pad_q  <= link_pad_d;
      lane_q      <= lane_d;
      lane_pad_q  <= lane_pad_d;
      nfts_q      <= nfts_d;
      rate_q      <= rate_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      skp_pend_q  <= skp_pend_d;
      tmr_q       <= tmr_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
    end
  end

endmodule

// File: tb/tb_pcie_os_tx.sv
// Scoreboard bench for pcie_os_tx: directed requests push hand-computed beats into a
// queue; a negedge monitor pops and compares on every AXIS handshake.
module tb_pcie_os_tx;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_type_i = '0;
  logic [15:0] req_count_i = '0;
  logic [7:0]  req_link_i = '0;
  logic        req_link_pad_i = 1'b0;
  logic [4:0]  req_lane_i = '0;
  logic        req_lane_pad_i = 1'b0;
  logic [7:0]  req_nfts_i = '0;
  logic [7:0]  req_rate_i = '0;
  logic [7:0]  req_ctrl_i = '0;
  logic        skp_en_i = 1'b0;
  logic [31:0] m_axis_tdata_o;
  logic [3:0]  m_axis_tkeep_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tlast_o;
  logic [3:0]  m_axis_tuser_o;
  logic        m_axis_tready_i = 1'b1;
  logic        os_sent_o;
  logic        done_o;
  logic        busy_o;

  pcie_os_tx #(.SKP_INTERVAL(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_type_i(req_type_i), .req_count_i(req_count_i),
    .req_link_i(req_link_i), .req_link_pad_i(req_link_pad_i),
    .req_lane_i(req_lane_i), .req_lane_pad_i(req_lane_pad_i),
    .req_nfts_i(req_nfts_i), .req_rate_i(req_rate_i), .req_ctrl_i(req_ctrl_i),
    .skp_en_i(skp_en_i),
    .m_axis_tdata_o(m_axis_tdata_o), .m_axis_tkeep_o(m_axis_tkeep_o),
    .m_axis_tvalid_o(m_axis_tvalid_o), .m_axis_tlast_o(m_axis_tlast_o),
    .m_axis_tuser_o(m_axis_tuser_o), .m_axis_tready_i(m_axis_tready_i),
    .os_sent_o(os_sent_o), .done_o(done_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  user;
    logic        last;
    logic        os_sent;
    logic        done;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          skp_allowed = 1'b0;
  bit          prev_last = 1'b1;
  bit          prev_skp = 1'b0;
  int          skp_cnt = 0;
  int          hs_cnt = 0;
  bit          bp_mode = 1'b0;
  int          bp_idx = 0;
  bit          stall_prev = 1'b0;
  logic [37:0] held = '0;
  logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] u, input logic l,
                      input logic os, input logic dn);
    beat_t b;
    b.data = d; b.user = u; b.last = l; b.os_sent = os; b.done = dn;
    exp_q.push_back(b);
  endtask

  // n TS ordered sets with a hand-computed beat 0
  task automatic push_ts(input logic [31:0] b0, input logic [3:0] u0, input logic [7:0] rate,
                         input logic [7:0] ctrl, input logic [7:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      push(b0, u0, 1'b0, 1'b0, 1'b0);
      push({id, id, ctrl, rate}, 4'h0, 1'b0, 1'b0, 1'b0);
      push({id, id, id, id}, 4'h0, 1'b0, 1'b0, 1'b0);
      push({id, id, id, id}, 4'h0, 1'b1, 1'b1, (k == n - 1));
    end
  endtask

  // Present a request until accepted, then scramble the inputs
  task automatic issue(input logic [2:0] t, input logic [15:0] cnt, input logic [7:0] link,
                       input logic lpad, input logic [4:0] lane, input logic lnpad,
                       input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl);
    int w;
    @(posedge clk_i); #1;
    req_type_i = t; req_count_i = cnt; req_link_i = link; req_link_pad_i = lpad;
    req_lane_i = lane; req_lane_pad_i = lnpad; req_nfts_i = nfts; req_rate_i = rate;
    req_ctrl_i = ctrl; req_valid_i = 1'b1;
    w = 0;
    @(negedge clk_i);
    while (!req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 100) chk("accept_timeout", 64'(w), 64'd0);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_type_i = 3'($urandom); req_count_i = 16'($urandom); req_link_i = 8'($urandom);
    req_link_pad_i = 1'($urandom); req_lane_i = 5'($urandom); req_lane_pad_i = 1'($urandom);
    req_nfts_i = 8'($urandom); req_rate_i = 8'($urandom); req_ctrl_i = 8'($urandom);
  endtask

  // Cycles from accept to done_o (1 = first beat cycle)
  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (!done_o && n < bound);
    if (!done_o) chk("done_timeout", 64'(n), 64'(bound + 1));
  endtask

  task automatic drain_check(input string name);
    repeat (3) @(negedge clk_i);
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Backpressure driver
  initial begin
    forever begin
      @(posedge clk_i); #1;
      if (bp_mode) begin
        m_axis_tready_i = bp_pat[bp_idx % 4];
        bp_idx++;
      end else begin
        m_axis_tready_i = 1'b1;
      end
    end
  end

  // Monitor: hold stability, SKP placement, scoreboard compare on handshake
  always @(negedge clk_i) begin
    beat_t e;
    if (rst_i) begin
      stall_prev = 1'b0;
      prev_last  = 1'b1;
      prev_skp   = 1'b0;
    end else begin
      if (stall_prev)
        chk("stall_hold", 64'({m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, m_axis_tvalid_o}),
            64'(held));
      if (m_axis_tvalid_o && m_axis_tready_i) begin
        hs_cnt++;
        if (m_axis_tdata_o == 32'h1C1C1CBC && m_axis_tuser_o == 4'hF) begin
          checks++;
          if (!skp_allowed || !prev_last || prev_skp || !m_axis_tlast_o || os_sent_o || done_o) begin
            errors++;
            $display("FAIL skp_place: allowed=%0b prev_last=%0b prev_skp=%0b last=%0b os=%0b done=%0b required allowed=1 prev_last=1 prev_skp=0 last=1 os=0 done=0",
                     skp_allowed, prev_last, prev_skp, m_axis_tlast_o, os_sent_o, done_o);
          end
          skp_cnt++;
          prev_skp = 1'b1;
        end else begin
          prev_skp = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %h user %h, required no beat", m_axis_tdata_o, m_axis_tuser_o);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'({m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, os_sent_o, done_o}),
                64'(e));
          end
        end
        prev_last = m_axis_tlast_o;
      end else if (os_sent_o || done_o) begin
        checks++;
        errors++;
        $display("FAIL stray_pulse: os_sent=%0b done=%0b required 0 0", os_sent_o, done_o);
      end
      stall_prev = m_axis_tvalid_o && !m_axis_tready_i;
      held = {m_axis_tdata_o, m_axis_tuser_o, m_axis_tlast_o, m_axis_tvalid_o};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    int w;

    // Reset state
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    chk("rst_tkeep", 64'(m_axis_tkeep_o), 64'hF);
    chk("rst_status", 64'({busy_o, done_o, os_sent_o, m_axis_tlast_o, m_axis_tdata_o}), 64'd0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // TS1 x2, no gaps
    for (int k = 0; k < 2; k++) begin
      push(32'h200301BC, 4'b0001, 1'b0, 1'b0, 1'b0);
      push(32'h4A4A0002, 4'b0000, 1'b0, 1'b0, 1'b0);
      push(32'h4A4A4A4A, 4'b0000, 1'b0, 1'b0, 1'b0);
      push(32'h4A4A4A4A, 4'b0000, 1'b1, 1'b1, (k == 1));
    end
    issue(3'd0, 16'd2, 8'h01, 1'b0, 5'd3, 1'b0, 8'h20, 8'h02, 8'h00);
    chk("busy_after_accept", 64'(busy_o), 64'd1);
    wait_done(50, n);
    chk("ts1_latency", 64'(n), 64'd8);
    drain_check("ts1_drain");
    chk("busy_after_done", 64'(busy_o), 64'd0);

    // TS2 with link and lane PAD
    push_ts(32'h1FF7F7BC, 4'b0111, 8'h02, 8'h08, 8'h45, 1);
    issue(3'd1, 16'd1, 8'h55, 1'b1, 5'd7, 1'b1, 8'h1F, 8'h02, 8'h08);
    wait_done(50, n);
    drain_check("ts2_drain");

    // EIOS: single beat, done with it
    push(32'h7C7C7CBC, 4'hF, 1'b1, 1'b1, 1'b1);
    issue(3'd2, 16'd1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    wait_done(50, n);
    chk("eios_latency", 64'(n), 64'd1);
    drain_check("eios_drain");

    // EIEOS with count 0 (sent once)
    push(32'hFCFCFCBC, 4'hF, 1'b0, 1'b0, 1'b0);
    push(32'hFCFCFCFC, 4'hF, 1'b0, 1'b0, 1'b0);
    push(32'hFCFCFCFC, 4'hF, 1'b0, 1'b0, 1'b0);
    push(32'h4AFCFCFC, 4'b0111, 1'b1, 1'b1, 1'b1);
    issue(3'd3, 16'd0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    wait_done(50, n);
    drain_check("eieos_drain");

    // Reserved type 5 behaves as TS1
    push_ts(32'h0A0C33BC, 4'b0001, 8'h01, 8'h04, 8'h4A, 1);
    issue(3'd5, 16'd1, 8'h33, 1'b0, 5'd12, 1'b0, 8'h0A, 8'h01, 8'h04);
    wait_done(50, n);
    drain_check("rsvd_drain");

    // Backpressure: tready pattern 1,0,0,1
    bp_idx = 0;
    bp_mode = 1'b1;
    hs0 = hs_cnt;
    push_ts(32'h080010BC, 4'b0001, 8'h01, 8'h00, 8'h4A, 1);
    issue(3'd0, 16'd1, 8'h10, 1'b0, 5'd0, 1'b0, 8'h08, 8'h01, 8'h00);
    wait_done(100, n);
    @(negedge clk_i);
    bp_mode = 1'b0;
    drain_check("bp_drain");
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'd4);

    // SKP insertion with interval 8 over TS1 x4
    skp_allowed = 1'b1;
    skp_cnt = 0;
    skp_en_i = 1'b1;
    push_ts(32'h400102BC, 4'b0001, 8'h02, 8'h01, 8'h4A, 4);
    issue(3'd0, 16'd4, 8'h02, 1'b0, 5'd1, 1'b0, 8'h40, 8'h02, 8'h01);
    wait_done(200, n);
    skp_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    skp_allowed = 1'b0;
    drain_check("skp_drain");
    chk("skp_seen", 64'(skp_cnt > 0), 64'd1);
    chk("skp_idle", 64'({m_axis_tvalid_o, req_ready_o}), 64'b01);

    // Reset during beat 2 of a TS1
    push_ts(32'h000000BC, 4'b0001, 8'h00, 8'h00, 8'h4A, 1);
    hs0 = hs_cnt;
    issue(3'd0, 16'd1, 8'h00, 1'b0, 5'd0, 1'b0, 8'h00, 8'h00, 8'h00);
    w = 0;
    while ((hs_cnt - hs0) < 2 && w < 50) begin
      @(negedge clk_i);
      w++;
    end
    chk("rst_mid_progress", 64'(hs_cnt - hs0), 64'd2);
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_tvalid", 64'(m_axis_tvalid_o), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_ready_busy", 64'({req_ready_o, busy_o, done_o}), 64'b100);
    push_ts(32'h101F07BC, 4'b0001, 8'h02, 8'h00, 8'h4A, 1);
    issue(3'd0, 16'd1, 8'h07, 1'b0, 5'd31, 1'b0, 8'h10, 8'h02, 8'h00);
    wait_done(50, n);
    chk("rst_restart_latency", 64'(n), 64'd4);
    drain_check("rst_restart_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
